// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter in front of a single memory port. A command is
// captured in IDLE, presented to memory for MEM_LAT cycles (ACCESS), and
// completed with a one-cycle done pulse (RESP). All outputs are flops.
//
// Parameters:
//   MEM_LAT   memory access cycles per transfer (1..15)
// Optional feature macro:
//   ARB_RR_EN defined   -> round-robin on simultaneous requests
//   ARB_RR_EN undefined -> fixed priority, m0 over m1
//
// Ports:
//   clk                 clock, rising edge
//   rst                 synchronous reset, active low
//   m0_* / m1_*         requester ports: req, we, addr, wdata, wstrb in;
//                       gnt, done pulses and rdata out (m0 = core, m1 = DMA)
//   mem_en/we/addr/wdata/wstrb  memory command outputs
//   mem_rdata           memory read data, valid in the last ACCESS cycle
//   busy                high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;       // 0 = m0, 1 = m1
    logic        m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
    logic        m0_done_q, m0_done_d, m1_done_q, m1_done_d;
    logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic        mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        busy_q, busy_d;
    logic        win_s;                  // 1 = m1 wins the current arbitration

`ifdef ARB_RR_EN
    logic        last_q, last_d;         // requester granted most recently

    // On a tie the requester that was not granted last wins.
    assign win_s = m1_req & (~m0_req | ~last_q);
`else
    // Fixed priority: m1 only wins when m0 is not asking.
    assign win_s = ~m0_req;
`endif

    // Next-state and next-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_done_d   = 1'b0;
        m1_done_d   = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
`ifdef ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d     = ACCESS;
                    cnt_d       = 4'(MEM_LAT - 1);
                    owner_d     = win_s;
                    m0_gnt_d    = ~win_s;
                    m1_gnt_d    = win_s;
                    // The captured command drives memory directly from these flops.
                    mem_en_d    = 1'b1;
                    mem_we_d    = win_s ? m1_we    : m0_we;
                    mem_addr_d  = win_s ? m1_addr  : m0_addr;
                    mem_wdata_d = win_s ? m1_wdata : m0_wdata;
                    mem_wstrb_d = win_s ? m1_wstrb : m0_wstrb;
`ifdef ARB_RR_EN
                    last_d      = win_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    mem_en_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'd0;
                    mem_wdata_d = 32'd0;
                    mem_wstrb_d = 4'd0;
                    m0_done_d   = ~owner_q;
                    m1_done_d   = owner_q;
                    // Only loads update the owner's read data.
                    if (!mem_we_q) begin
                        if (owner_q) begin
                            m1_rdata_d = mem_rdata;
                        end else begin
                            m0_rdata_d = mem_rdata;
                        end
                    end else begin
                        m0_rdata_d = m0_rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                // Corrupted state: recover to IDLE with every output cleared.
                state_d     = IDLE;
                cnt_d       = 4'd0;
                owner_d     = 1'b0;
                m0_rdata_d  = 32'd0;
                m1_rdata_d  = 32'd0;
                mem_en_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = 32'd0;
                mem_wdata_d = 32'd0;
                mem_wstrb_d = 4'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= 1'b0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_done_q   <= 1'b0;
            m1_done_q   <= 1'b0;
            m0_rdata_q  <= 32'd0;
            m1_rdata_q  <= 32'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
            busy_q      <= 1'b0;
`ifdef ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            m0_done_q   <= m0_done_d;
            m1_done_q   <= m1_done_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            busy_q      <= busy_d;
`ifdef ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign m0_done   = m0_done_q;
    assign m1_done   = m1_done_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a constant vector table of single
// transfers, directed sequences (contention, reset during access, MEM_LAT=1),
// and a randomized run against a transaction-level reference model.
// Honors ARB_RR_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int L = 2;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_gnt, m0_done, m1_gnt, m1_done;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    // second instance with MEM_LAT = 1
    logic        l1_m0_gnt, l1_m0_done, l1_m1_gnt, l1_m1_done;
    logic [31:0] l1_m0_rdata, l1_m1_rdata;
    logic        l1_mem_en, l1_mem_we, l1_busy;
    logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic [3:0]  l1_mem_wstrb;

    logic        use_fixed;
    logic [31:0] fixed_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural memory contents used in the random run.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    // Outside ACCESS the memory returns garbage so mistimed captures show up.
    assign mem_rdata    = mem_en    ? (use_fixed ? fixed_rdata : memf(mem_addr))    : 32'h0BAD_F00D;
    assign l1_mem_rdata = l1_mem_en ? (use_fixed ? fixed_rdata : memf(l1_mem_addr)) : 32'h0BAD_F00D;

    mem_arbiter #(.MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_gnt(l1_m0_gnt), .m0_done(l1_m0_done), .m0_rdata(l1_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_gnt(l1_m1_gnt), .m1_done(l1_m1_done), .m1_rdata(l1_m1_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_wstrb(l1_mem_wstrb), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    typedef struct {
        logic        r0, r1, we0, we1;
        logic [31:0] a0, a1, d0, d1;
        logic [3:0]  s0, s1;
        logic [31:0] rd;
        logic        win_fix, win_rr;
    } vec_t;

    vec_t        tbl [6];
    logic [31:0] erd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_in();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_cmd(input string tag, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        chk({tag, "_mem_en"},    {31'd0, mem_en}, 32'd1);
        chk({tag, "_mem_we"},    {31'd0, mem_we}, {31'd0, we});
        chk({tag, "_mem_addr"},  mem_addr, a);
        chk({tag, "_mem_wdata"}, mem_wdata, d);
        chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, s});
    endtask

    // Random-run driver for one requester: hold until granted, then maybe reissue.
    task automatic drive_one(input logic granted, inout logic req, inout logic we,
                             inout logic [31:0] a, inout logic [31:0] d, inout logic [3:0] s);
        if (granted || (!req && $urandom_range(0, 2) == 0)) begin
            req = (!granted) || ($urandom_range(0, 1) == 1);
            we  = 1'($urandom_range(0, 1));
            a   = $urandom;
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
        end else if (req && $urandom_range(0, 9) == 0) begin
            req = 1'b0;
        end else begin
            req = req;
        end
    endtask

    initial begin
        int          w;
        logic        wwe;
        logic [31:0] wa, wd;
        logic [3:0]  ws;
        int          ngnt;
        int          gseq [3];
        int          p;
        logic        mw, mlast, mwe;
        logic [31:0] ma, md;
        logic [3:0]  ms;
        logic        g0, g1;

        //           r0    r1    we0   we1   a0            a1            d0            d1            s0    s1    rd            fix   rr
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_0300, 32'h0, 32'h0, 4'h0, 4'h0, 32'h1111_2222, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0200, 32'h0, 32'h1234_5678, 4'h0, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0080, 32'hAAAA_5555, 32'h0, 4'h3, 4'h0, 32'h0F0F_0F0F, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0000_0088, 32'h0, 32'h55AA_55AA, 4'h0, 4'hC, 32'h1357_9BDF, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_01FC, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'h8, 4'h0, 32'h2468_ACE0, 1'b0, 1'b0};

        use_fixed = 1'b1;
        fixed_rdata = 32'h0;
        rst = 1'b0;
        clear_in();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ---- reset state ----
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_mem_en",   {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_gnt",      {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("rst_done",     {30'd0, m1_done, m0_done}, 32'd0);
        chk("rst_rdata0",   m0_rdata, 32'd0);
        chk("rst_rdata1",   m1_rdata, 32'd0);
        chk("rst_l1_busy",  {31'd0, l1_busy}, 32'd0);

        // ---- table-driven single transfers ----
        erd[0] = 32'd0;
        erd[1] = 32'd0;
        for (int i = 0; i < 6; i++) begin
            m0_req = tbl[i].r0; m0_we = tbl[i].we0; m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0; m0_wstrb = tbl[i].s0;
            m1_req = tbl[i].r1; m1_we = tbl[i].we1; m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1; m1_wstrb = tbl[i].s1;
            fixed_rdata = tbl[i].rd;
            w   = RR ? int'(tbl[i].win_rr) : int'(tbl[i].win_fix);
            wwe = w ? tbl[i].we1 : tbl[i].we0;
            wa  = w ? tbl[i].a1  : tbl[i].a0;
            wd  = w ? tbl[i].d1  : tbl[i].d0;
            ws  = w ? tbl[i].s1  : tbl[i].s0;
            @(negedge clk);
            chk("tbl_gnt", {30'd0, m1_gnt, m0_gnt}, (w == 1) ? 32'd2 : 32'd1);
            chk("tbl_busy", {31'd0, busy}, 32'd1);
            chk_cmd("tbl_c1", wwe, wa, wd, ws);
            clear_in();
            for (int c = 2; c <= L; c++) begin
                @(negedge clk);
                chk("tbl_gnt_off", {30'd0, m1_gnt, m0_gnt}, 32'd0);
                chk_cmd("tbl_cn", wwe, wa, wd, ws);
            end
            @(negedge clk);
            if (!wwe) erd[w] = tbl[i].rd;
            chk("tbl_done", {30'd0, m1_done, m0_done}, (w == 1) ? 32'd2 : 32'd1);
            chk("tbl_mem_en_resp", {31'd0, mem_en}, 32'd0);
            chk("tbl_rdata0", m0_rdata, erd[0]);
            chk("tbl_rdata1", m1_rdata, erd[1]);
            @(negedge clk);
            chk("tbl_idle_busy", {31'd0, busy}, 32'd0);
            chk("tbl_idle_done", {30'd0, m1_done, m0_done}, 32'd0);
        end

        // ---- contention: both requests held for three grants ----
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h0000_0010;
        m1_req = 1'b1; m1_addr = 32'h0000_0020;
        ngnt = 0;
        for (int c = 0; c < 40 && ngnt < 3; c++) begin
            @(negedge clk);
            if (m0_gnt && m1_gnt) chk("cont_dual_gnt", 32'd1, 32'd0);
            if (m0_done && m1_done) chk("cont_dual_done", 32'd1, 32'd0);
            if (m0_gnt || m1_gnt) begin
                gseq[ngnt] = int'(m1_gnt);
                ngnt++;
            end
        end
        chk("cont_count", ngnt, 32'd3);
        if (ngnt == 3) begin
            chk("cont_g0", gseq[0], 32'd0);
            chk("cont_g1", gseq[1], RR ? 32'd1 : 32'd0);
            chk("cont_g2", gseq[2], 32'd0);
        end
        clear_in();
        repeat (L + 3) @(negedge clk);

        // ---- reset in the second ACCESS cycle ----
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h0000_0030; fixed_rdata = 32'h7777_8888;
        @(negedge clk);
        chk("ra_gnt", {31'd0, m0_gnt}, 32'd1);
        clear_in();
        @(negedge clk);
        chk("ra_mem_en_c2", {31'd0, mem_en}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("ra_mem_en", {31'd0, mem_en}, 32'd0);
        chk("ra_busy", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk("ra_no_done", {30'd0, m1_done, m0_done}, 32'd0);
            @(negedge clk);
        end
        m0_req = 1'b1; m0_addr = 32'h0000_0034; fixed_rdata = 32'h9999_AAAA;
        @(negedge clk);
        chk("ra_regnt", {31'd0, m0_gnt}, 32'd1);
        clear_in();
        repeat (L) @(negedge clk);
        chk("ra_redone", {31'd0, m0_done}, 32'd1);
        chk("ra_rerdata", m0_rdata, 32'h9999_AAAA);
        @(negedge clk);

        // ---- MEM_LAT = 1 instance ----
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h0000_0040; fixed_rdata = 32'h5A5A_0001;
        @(negedge clk);
        chk("l1_gnt", {31'd0, l1_m0_gnt}, 32'd1);
        chk("l1_mem_en_c1", {31'd0, l1_mem_en}, 32'd1);
        chk("l1_mem_addr", l1_mem_addr, 32'h0000_0040);
        clear_in();
        @(negedge clk);
        chk("l1_mem_en_c2", {31'd0, l1_mem_en}, 32'd0);
        chk("l1_done", {31'd0, l1_m0_done}, 32'd1);
        chk("l1_rdata", l1_m0_rdata, 32'h5A5A_0001);
        @(negedge clk);
        chk("l1_busy_c3", {31'd0, l1_busy}, 32'd0);

        // ---- randomized run against a transaction-level model ----
        do_reset();
        use_fixed = 1'b0;
        p = 0; mw = 1'b0; mlast = 1'b1; mwe = 1'b0;
        ma = 32'd0; md = 32'd0; ms = 4'd0;
        erd[0] = 32'd0; erd[1] = 32'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // p counts cycles since capture: 1..L access, L+1 response, 0 idle.
            chk("rnd_gnt", {30'd0, m1_gnt, m0_gnt},
                (p == 1) ? (mw ? 32'd2 : 32'd1) : 32'd0);
            chk("rnd_done", {30'd0, m1_done, m0_done},
                (p == L + 1) ? (mw ? 32'd2 : 32'd1) : 32'd0);
            chk("rnd_busy", {31'd0, busy}, (p != 0) ? 32'd1 : 32'd0);
            if (p >= 1 && p <= L) chk_cmd("rnd", mwe, ma, md, ms);
            else chk("rnd_mem_en", {31'd0, mem_en}, 32'd0);
            chk("rnd_rdata0", m0_rdata, erd[0]);
            chk("rnd_rdata1", m1_rdata, erd[1]);

            g0 = (p == 1) && !mw;
            g1 = (p == 1) && mw;
            drive_one(g0, m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb);
            drive_one(g1, m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb);

            if (p == 0) begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) mw = RR ? ~mlast : 1'b0;
                    else mw = m1_req;
                    mlast = mw;
                    mwe = mw ? m1_we    : m0_we;
                    ma  = mw ? m1_addr  : m0_addr;
                    md  = mw ? m1_wdata : m0_wdata;
                    ms  = mw ? m1_wstrb : m0_wstrb;
                    p = 1;
                end
            end else if (p == L + 1) begin
                p = 0;
            end else begin
                p = p + 1;
                if (p == L + 1 && !mwe) erd[mw] = memf(ma);
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 2, meaning memory access cycles per transfer; legal range 1..15.
REQ-002 The block SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have ports m0_req / m1_req  input  1  access request: m0 is core (fetch/load/store), m1 is DMA/debug.
REQ-005 The block SHALL have ports mX_we  input  1  write enable, 1 = store, 0 = load.
REQ-006 The block SHALL have ports mX_addr  input  32  byte address.
REQ-007 The block SHALL have ports mX_wdata  input  32  store data.
REQ-008 The block SHALL have ports mX_wstrb  input  4  store byte strobes.
REQ-009 The block SHALL have ports mX_gnt  output  1  one-cycle pulse marking command capture.
REQ-010 The block SHALL have ports mX_done  output  1  one-cycle pulse marking access completion.
REQ-011 The block SHALL have ports mX_rdata  output  32  load data; valid when mX_done is high for a load.
REQ-012 The block SHALL have ports mem_en, mem_we  output  1  memory strobe and write.
REQ-013 The block SHALL have ports mem_addr, mem_wdata  output  32  memory address and data; mem_wstrb  output  4  memory strobes.
REQ-014 The block SHALL have port mem_rdata  input  32  memory read data, valid in last ACCESS cycle.
REQ-015 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL implement states IDLE, ACCESS and RESP with these transitions:
- IDLE to ACCESS when any req is high.
- ACCESS to RESP when the counter reaches 0.
- RESP to IDLE unconditionally.
REQ-017 In IDLE with any req high, at the next edge the block SHALL:
- Latch the winner's we, addr, wdata and wstrb plus an owner bit.
- Load the counter with MEM_LAT-1.
- Register the winner's gnt for exactly the first ACCESS cycle.
REQ-018 Arbitration SHALL be fixed priority, m0 over m1, unless ARB_RR_EN is defined (REQ-031).
REQ-019 In ACCESS the block SHALL drive mem_en=1 and mem_* from the latched command for exactly MEM_LAT cycles, decrementing the counter each cycle.
REQ-020 On the edge leaving ACCESS the block SHALL register mem_rdata into the owner's rdata, for loads only.
REQ-021 In RESP the block SHALL pulse the owner's done; mem_en SHALL be 0.
REQ-022 Latency SHALL be: req sampled at cycle 0, gnt at cycle 1, done at cycle MEM_LAT+1, next grant no earlier than cycle MEM_LAT+3.
REQ-023 Requests SHALL NOT be sampled in ACCESS or RESP; the requester SHALL hold req and command stable until gnt and deassert req the cycle after gnt unless it wants a further access.
REQ-024 A req dropped before capture SHALL be ignored; after capture the access SHALL complete regardless of req.
REQ-025 The non-owner's rdata SHALL hold its value; a store SHALL NOT modify the owner's rdata.
REQ-026 mX_gnt and mX_done SHALL never be high for both requesters in the same cycle.
REQ-027 Illegal state encodings SHALL return to IDLE on the next edge with all outputs 0.

Reset
REQ-028 With rst=0 at an edge the block SHALL:
- Force state IDLE and counter 0.
- Clear all gnt, done, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, rdata and busy to 0.
- Set the last-grant pointer to m1.
REQ-029 A reset during ACCESS SHALL abort the transfer, drop mem_en on the next cycle and produce no done.

Configuration
REQ-030 Macro ARB_RR_EN SHALL select the arbitration policy.
REQ-031 With ARB_RR_EN defined, on a simultaneous request the requester not granted last SHALL win, and the last-grant pointer SHALL update on every capture. With ARB_RR_EN undefined, m0 SHALL always win and no pointer register SHALL exist.

Verification
REQ-032 Single load, MEM_LAT=2: m0 load at addr 0x100, mem_rdata=0xDEADBEEF -> m0_gnt at cycle 1, mem_en high in cycles 1-2, m0_done and m0_rdata=0xDEADBEEF at cycle 3.
REQ-033 Store from m1: addr 0x200, wdata 0x12345678, wstrb 0xF -> mem_we=1 with those values for 2 cycles, m1_done at cycle 3, m1_rdata unchanged.
REQ-034 Contention, both req held high for 3 transfers: without ARB_RR_EN grants are m0,m0,m0; with ARB_RR_EN grants are m0,m1,m0.
REQ-035 MEM_LAT=1 boundary: m0 load -> mem_en high for 1 cycle, done at cycle 2, busy low at cycle 3.
REQ-036 Reset mid-access: rst=0 in the second ACCESS cycle -> mem_en=0, busy=0 next cycle, no done pulse, the next m0 request is served normally.
